// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 memory arbiter: FSM states and grant IDs.
package msrv32_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arb_state_e;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/msrv32_bus_timer.sv
// Bus watchdog: counts busy cycles without an ack and flags expiry on the
// cycle the count would reach TIMEOUT. TIMEOUT = 0 removes the counter.
module msrv32_bus_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic start,
   input  logic ack,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] cnt_q;

         // Expiry fires on the TIMEOUT-th ack-less busy cycle; an ack in the
         // same cycle takes precedence.
         assign expired = start && !ack && (cnt_q == CW'(TIMEOUT - 1));

         // Count while a transaction is waiting; clear when idle or finished.
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in)
               cnt_q <= '0;
            else if (!start || ack || expired)
               cnt_q <= '0;
            else
               cnt_q <= cnt_q + 1'b1;
         end
      end
   endgenerate

endmodule

// File: rtl/msrv32_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single msrv32 memory
// port: round-robin tie-break, one outstanding transaction, bus timeout and
// discard of an in-flight fetch on trap flush.
module msrv32_mem_arbiter
   import msrv32_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                if_req_in,
   input  logic [ADDR_W-1:0]   if_addr_in,
   output logic                if_gnt_out,
   output logic                if_rvalid_out,
   output logic [DATA_W-1:0]   if_rdata_out,
   output logic                if_err_out,
   input  logic                flush_in,
   input  logic                dm_req_in,
   input  logic                dm_we_in,
   input  logic [ADDR_W-1:0]   dm_addr_in,
   input  logic [DATA_W-1:0]   dm_wdata_in,
   input  logic [DATA_W/8-1:0] dm_wmask_in,
   output logic                dm_gnt_out,
   output logic                dm_rvalid_out,
   output logic [DATA_W-1:0]   dm_rdata_out,
   output logic                dm_err_out,
   output logic                bus_req_out,
   output logic                bus_we_out,
   output logic [ADDR_W-1:0]   bus_addr_out,
   output logic [DATA_W-1:0]   bus_wdata_out,
   output logic [DATA_W/8-1:0] bus_wmask_out,
   input  logic                bus_ack_in,
   input  logic [DATA_W-1:0]   bus_rdata_in,
   input  logic                bus_err_in
);

   arb_state_e          state_q;
   logic                last_q;
   logic                discard_q;
   logic                bus_req_q, bus_we_q;
   logic [ADDR_W-1:0]   bus_addr_q;
   logic [DATA_W-1:0]   bus_wdata_q;
   logic [DATA_W/8-1:0] bus_wmask_q;
   logic                if_rvalid_q, if_err_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic                dm_rvalid_q, dm_err_q;
   logic [DATA_W-1:0]   dm_rdata_q;

   logic busy, expired, ack_done, done, drop_if;

   assign busy     = (state_q != IDLE);
   assign ack_done = busy && bus_ack_in;
   assign done     = ack_done || expired;
   // A flush landing on the completion edge still kills the fetch response.
   assign drop_if  = discard_q || flush_in;

   // Grants are only offered in IDLE; on a tie the requester that did not
   // win last time goes first. Held low while reset is asserted.
   assign if_gnt_out = !rst_in && (state_q == IDLE) && if_req_in &&
                       (!dm_req_in || last_q == GNT_DM);
   assign dm_gnt_out = !rst_in && (state_q == IDLE) && dm_req_in &&
                       (!if_req_in || last_q == GNT_IF);

   msrv32_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .start   (busy),
      .ack     (bus_ack_in),
      .expired (expired)
   );

   // Arbitration FSM with registered bus request and response outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         last_q      <= GNT_DM;
         discard_q   <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wmask_q <= '0;
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rvalid_q <= 1'b0;
         dm_err_q    <= 1'b0;
         dm_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_gnt_out) begin
                  state_q     <= IF_BUSY;
                  last_q      <= GNT_IF;
                  discard_q   <= flush_in;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= if_addr_in;
                  bus_wdata_q <= '0;
                  bus_wmask_q <= '1;
               end else if (dm_gnt_out) begin
                  state_q     <= DM_BUSY;
                  last_q      <= GNT_DM;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= dm_we_in;
                  bus_addr_q  <= dm_addr_in;
                  bus_wdata_q <= dm_wdata_in;
                  bus_wmask_q <= dm_wmask_in;
               end
            end
            IF_BUSY: begin
               if (done) begin
                  state_q   <= IDLE;
                  bus_req_q <= 1'b0;
                  discard_q <= 1'b0;
                  if (!drop_if) begin
                     if_rvalid_q <= 1'b1;
                     if_err_q    <= ack_done ? bus_err_in : 1'b1;
                     if_rdata_q  <= ack_done ? bus_rdata_in : '0;
                  end
               end else if (flush_in) begin
                  discard_q <= 1'b1;
               end
            end
            DM_BUSY: begin
               if (done) begin
                  state_q     <= IDLE;
                  bus_req_q   <= 1'b0;
                  dm_rvalid_q <= 1'b1;
                  dm_err_q    <= ack_done ? bus_err_in : 1'b1;
                  dm_rdata_q  <= (ack_done && !bus_we_q) ? bus_rdata_in : '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_req_out   = bus_req_q;
   assign bus_we_out    = bus_we_q;
   assign bus_addr_out  = bus_addr_q;
   assign bus_wdata_out = bus_wdata_q;
   assign bus_wmask_out = bus_wmask_q;
   assign if_rvalid_out = if_rvalid_q;
   assign if_err_out    = if_err_q;
   assign if_rdata_out  = if_rdata_q;
   assign dm_rvalid_out = dm_rvalid_q;
   assign dm_err_out    = dm_err_q;
   assign dm_rdata_out  = dm_rdata_q;

endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// Bench for msrv32_mem_arbiter: table of single transactions plus hand
// sequences (alternation, long ack, timeout, mid-transaction reset).
// Responses are scoreboarded through per-requester queues.
module tb_msrv32_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 0, flush = 0, dm_req = 0, dm_we = 0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0, bus_rdata = '0;
   logic [MW-1:0] dm_wmask = '0;
   logic          bus_ack = 0, bus_err = 0;

   logic          if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
   logic [DW-1:0] if_rdata, dm_rdata, bus_wdata;
   logic          bus_req, bus_we;
   logic [AW-1:0] bus_addr;
   logic [MW-1:0] bus_wmask;

   logic          t4_if_gnt, t4_if_rvalid, t4_if_err, t4_dm_gnt, t4_dm_rvalid, t4_dm_err;
   logic [DW-1:0] t4_if_rdata, t4_dm_rdata, t4_bus_wdata;
   logic          t4_bus_req, t4_bus_we;
   logic [AW-1:0] t4_bus_addr;
   logic [MW-1:0] t4_bus_wmask;

   always #5 clk = ~clk;

   msrv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk_in(clk), .rst_in(rst),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_gnt_out(if_gnt),
      .if_rvalid_out(if_rvalid), .if_rdata_out(if_rdata), .if_err_out(if_err),
      .flush_in(flush),
      .dm_req_in(dm_req), .dm_we_in(dm_we), .dm_addr_in(dm_addr),
      .dm_wdata_in(dm_wdata), .dm_wmask_in(dm_wmask), .dm_gnt_out(dm_gnt),
      .dm_rvalid_out(dm_rvalid), .dm_rdata_out(dm_rdata), .dm_err_out(dm_err),
      .bus_req_out(bus_req), .bus_we_out(bus_we), .bus_addr_out(bus_addr),
      .bus_wdata_out(bus_wdata), .bus_wmask_out(bus_wmask),
      .bus_ack_in(bus_ack), .bus_rdata_in(bus_rdata), .bus_err_in(bus_err)
   );

   // Second instance with a short watchdog, fed the same stimulus.
   msrv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_t4 (
      .clk_in(clk), .rst_in(rst),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_gnt_out(t4_if_gnt),
      .if_rvalid_out(t4_if_rvalid), .if_rdata_out(t4_if_rdata), .if_err_out(t4_if_err),
      .flush_in(flush),
      .dm_req_in(dm_req), .dm_we_in(dm_we), .dm_addr_in(dm_addr),
      .dm_wdata_in(dm_wdata), .dm_wmask_in(dm_wmask), .dm_gnt_out(t4_dm_gnt),
      .dm_rvalid_out(t4_dm_rvalid), .dm_rdata_out(t4_dm_rdata), .dm_err_out(t4_dm_err),
      .bus_req_out(t4_bus_req), .bus_we_out(t4_bus_we), .bus_addr_out(t4_bus_addr),
      .bus_wdata_out(t4_bus_wdata), .bus_wmask_out(t4_bus_wmask),
      .bus_ack_in(bus_ack), .bus_rdata_in(bus_rdata), .bus_err_in(bus_err)
   );

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   typedef struct {
      bit            is_dm;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [MW-1:0] mask;
      int            delay;
      logic [DW-1:0] rdata;
      bit            err;
      int            flush;   // 0 none, 1 with grant, 2 while busy
   } vec_t;

   rsp_t if_q[$];
   rsp_t dm_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard for the main instance.
   always @(negedge clk) begin
      rsp_t r;
      if (if_rvalid) begin
         if (if_q.size() == 0) cmp("if_unexpected_rvalid", 1, 0);
         else begin
            r = if_q.pop_front();
            cmp("if_rdata", if_rdata, r.rdata);
            cmp("if_err", if_err, r.err);
         end
      end
      if (dm_rvalid) begin
         if (dm_q.size() == 0) cmp("dm_unexpected_rvalid", 1, 0);
         else begin
            r = dm_q.pop_front();
            cmp("dm_rdata", dm_rdata, r.rdata);
            cmp("dm_err", dm_err, r.err);
         end
      end
   end

   // One isolated transaction: grant at c0, bus held until ack, rvalid after.
   task automatic do_txn(input vec_t v);
      logic [DW-1:0] exp_wdata;
      logic [MW-1:0] exp_mask;
      bit            exp_we, drop;
      rsp_t          r;
      exp_we    = v.is_dm && v.we;
      exp_wdata = v.is_dm ? v.wdata : '0;
      exp_mask  = v.is_dm ? v.mask : '1;
      drop      = !v.is_dm && (v.flush != 0);
      if (v.is_dm) begin
         dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_wmask = v.mask;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
      flush = (v.flush == 1);
      @(negedge clk);
      cmp("gnt", v.is_dm ? dm_gnt : if_gnt, 1);
      cmp("other_gnt", v.is_dm ? if_gnt : dm_gnt, 0);
      r.rdata = (v.is_dm && v.we) ? '0 : v.rdata;
      r.err   = v.err;
      if (!drop) begin
         if (v.is_dm) dm_q.push_back(r);
         else if_q.push_back(r);
      end
      step();
      if_req = 0; dm_req = 0; flush = (v.flush == 2);
      for (int d = 0; d <= v.delay; d++) begin
         if (d > 0) begin step(); flush = 0; end
         if (d == v.delay) begin bus_ack = 1; bus_rdata = v.rdata; bus_err = v.err; end
         @(negedge clk);
         cmp("bus_req", bus_req, 1);
         cmp("bus_we", bus_we, exp_we);
         cmp("bus_addr", bus_addr, v.addr);
         cmp("bus_wdata", bus_wdata, exp_wdata);
         cmp("bus_wmask", bus_wmask, exp_mask);
      end
      step();
      bus_ack = 0; bus_err = 0; flush = 0;
      @(negedge clk);
      cmp("bus_req_done", bus_req, 0);
      cmp("rvalid", v.is_dm ? dm_rvalid : if_rvalid, !drop);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[8];
      vec_t v;
      rsp_t r;
      vt[0] = '{0, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0000_0013, 0, 0};
      vt[1] = '{1, 0, 32'h0000_3000, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 0, 0};
      vt[2] = '{1, 1, 32'h0000_2004, 32'h1234_5678, 4'hC, 1, 32'hFFFF_FFFF, 0, 0};
      vt[3] = '{0, 0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'h00A0_0093, 1, 0};
      vt[4] = '{0, 0, 32'h0000_0108, 32'h0, 4'h0, 1, 32'h0000_0011, 0, 2};
      vt[5] = '{0, 0, 32'h0000_010C, 32'h0, 4'h0, 0, 32'h0000_0022, 0, 1};
      vt[6] = '{0, 0, 32'h0000_0110, 32'h0, 4'h0, 0, 32'h0000_0033, 0, 0};
      vt[7] = '{1, 0, 32'h0000_3004, 32'h0, 4'hF, 0, 32'h55AA_55AA, 1, 2};

      // Reset state, with requests present to show grants stay low.
      if_req = 1; dm_req = 1;
      step(); step();
      @(negedge clk);
      cmp("rst_if_gnt", if_gnt, 0);
      cmp("rst_dm_gnt", dm_gnt, 0);
      cmp("rst_bus_req", bus_req, 0);
      cmp("rst_bus_addr", bus_addr, 0);
      cmp("rst_bus_wmask", bus_wmask, 0);
      cmp("rst_rvalids", {if_rvalid, dm_rvalid}, 0);
      cmp("rst_rdata", {if_rdata, dm_rdata}, 0);
      if_req = 0; dm_req = 0;
      step();
      rst = 0;

      for (int i = 0; i < 8; i++) do_txn(vt[i]);

      // Timeout: no ack. Short-watchdog copy aborts after 4 busy cycles.
      dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_wmask = 4'hF;
      @(negedge clk);
      cmp("to_gnt", dm_gnt, 1);
      cmp("to_t4_gnt", t4_dm_gnt, 1);
      r.rdata = '0; r.err = 1;
      dm_q.push_back(r);
      for (int c = 1; c <= 4; c++) begin
         step();
         dm_req = 0;
         @(negedge clk);
         cmp("to_t4_bus_req", t4_bus_req, 1);
      end
      step();
      @(negedge clk);
      cmp("to_t4_bus_req_drop", t4_bus_req, 0);
      cmp("to_t4_rvalid", t4_dm_rvalid, 1);
      cmp("to_t4_err", t4_dm_err, 1);
      cmp("to_t4_rdata", t4_dm_rdata, 0);
      for (int c = 6; c <= 9; c++) begin
         step();
         @(negedge clk);
         if (c <= 8) cmp("to_bus_req", bus_req, 1);
         else begin
            cmp("to_bus_req_drop", bus_req, 0);
            cmp("to_rvalid", dm_rvalid, 1);
         end
      end
      step();
      bus_ack = 1; bus_rdata = 32'h7777_7777;
      step();
      bus_ack = 0;
      @(negedge clk);
      cmp("stray_ack_rvalid", {dm_rvalid, if_rvalid}, 0);
      cmp("stray_ack_t4_rvalid", {t4_dm_rvalid, t4_if_rvalid}, 0);
      step();

      // DM load with ack after 5 extra cycles.
      v = '{1, 0, 32'h0000_5000, 32'h0, 4'hF, 5, 32'h0BAD_F00D, 0, 0};
      do_txn(v);

      // Reset in the middle of a store.
      dm_req = 1; dm_we = 1; dm_addr = 32'h6000; dm_wdata = 32'hA5A5_A5A5; dm_wmask = 4'hF;
      @(negedge clk);
      cmp("mr_gnt", dm_gnt, 1);
      step();
      dm_req = 0;
      @(negedge clk);
      cmp("mr_bus_req", bus_req, 1);
      @(posedge clk);
      #3 rst = 1;
      #1;
      cmp("mr_bus_req", bus_req, 0);
      cmp("mr_bus_addr", bus_addr, 0);
      cmp("mr_bus_wdata", bus_wdata, 0);
      cmp("mr_bus_we", bus_we, 0);
      cmp("mr_dm_rdata", dm_rdata, 0);
      cmp("mr_if_rdata", if_rdata, 0);
      step();
      rst = 0; bus_ack = 1;
      @(negedge clk);
      cmp("mr_post_bus_req", bus_req, 0);
      step();
      bus_ack = 0;
      @(negedge clk);
      cmp("mr_post_rvalid", {dm_rvalid, if_rvalid}, 0);
      step();

      // Both requesting from reset: IF first, then strict alternation.
      if_req = 1; if_addr = 32'h200;
      dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wmask = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cmp("alt_if_gnt", if_gnt, (k % 2 == 0));
         cmp("alt_dm_gnt", dm_gnt, (k % 2 == 1));
         r.err = 0;
         if (k % 2 == 0) begin r.rdata = 32'h1000 + k; if_q.push_back(r); end
         else begin r.rdata = '0; dm_q.push_back(r); end
         step();
         if (k == 3) begin if_req = 0; dm_req = 0; end
         bus_ack = 1; bus_rdata = 32'h1000 + k;
         @(negedge clk);
         cmp("alt_bus_we", bus_we, (k % 2 == 1));
         cmp("alt_bus_addr", bus_addr, (k % 2 == 1) ? 32'h2000 : 32'h200);
         cmp("alt_bus_wmask", bus_wmask, (k % 2 == 1) ? 4'b0011 : 4'hF);
         cmp("alt_bus_wdata", bus_wdata, (k % 2 == 1) ? 32'hDEAD_BEEF : 32'h0);
         step();
         bus_ack = 0;
      end
      @(negedge clk);
      cmp("alt_last_rvalid", dm_rvalid, 1);
      step();
      step();

      cmp("if_q_empty", if_q.size(), 0);
      cmp("dm_q_empty", dm_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msrv32_mem_arbiter.md
Name: msrv32_mem_arbiter

Overview:
- Shares the single external memory port between two requesters: instruction fetch (IF) and load/store (DM).
- DM requests come from decoder-qualified accesses: mem_wr_req, load size/unsigned, misaligned already filtered.
- Registered request capture, one outstanding bus transaction, round-robin tie-break, bus timeout, and fetch-discard on trap flush.
- Sits between the msrv32 core datapath and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 255, cycles to wait for bus_ack_in before aborting; 0 disables timeout.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous active-high reset.
- if_req_in  input  1  fetch request; held until if_gnt_out.
- if_addr_in  input  ADDR_W  fetch address.
- if_gnt_out  output  1  fetch request accepted this cycle.
- if_rvalid_out  output  1  one-cycle pulse, fetch data valid.
- if_rdata_out  output  DATA_W  fetched instruction.
- if_err_out  output  1  qualifies if_rvalid_out; bus error or timeout.
- flush_in  input  1  trap/redirect; the outstanding fetch response is discarded.
- dm_req_in  input  1  load/store request; held until dm_gnt_out.
- dm_we_in  input  1  1 = store.
- dm_addr_in  input  ADDR_W  data address, word-aligned by the core.
- dm_wdata_in  input  DATA_W  store data.
- dm_wmask_in  input  DATA_W/8  byte enables.
- dm_gnt_out  output  1  data request accepted.
- dm_rvalid_out  output  1  completion pulse for loads and stores.
- dm_rdata_out  output  DATA_W  load data; 0 for stores.
- dm_err_out  output  1  qualifies dm_rvalid_out.
- bus_req_out  output  1  bus request; held until ack.
- bus_we_out  output  1  bus write enable.
- bus_addr_out  output  ADDR_W  bus address.
- bus_wdata_out  output  DATA_W  bus write data.
- bus_wmask_out  output  DATA_W/8  bus byte enables.
- bus_ack_in  input  1  transaction complete.
- bus_rdata_in  input  DATA_W  read data, valid with ack.
- bus_err_in  input  1  error, valid with ack.

Behaviour:
- Reset (async):
  - State IDLE; last_grant = DM, so the first tie goes to IF.
  - discard = 0; timer = 0.
  - All outputs 0, including the bus_* registers; bus_req_out drops immediately on rst_in mid-transaction.
  - The outstanding transaction is forgotten and no response is pulsed.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE, granting:
  - gnt outputs are combinational, asserted only in IDLE.
  - Only one requester active: it wins.
  - Both active: the requester not equal to last_grant wins.
  - The winner's gnt is high for one cycle.
  - On that edge the address/we/wdata/wmask are captured into the bus_* registers (IF: we = 0, wmask = all ones, wdata = 0), bus_req_out is set, last_grant is updated, and the state moves to the winner's BUSY state.
- BUSY:
  - bus_* outputs are stable and bus_req_out stays high.
  - The timer increments each cycle in which bus_ack_in = 0.
- Completion:
  - On the edge where bus_ack_in = 1: bus_req_out clears, state returns to IDLE, rdata is registered, and the owner's rvalid pulses in the next cycle.
  - err = bus_err_in.
  - Minimum latency is req→gnt (cycle 0), bus_req (cycle 1), ack (cycle 1), rvalid (cycle 2).
  - The next grant can occur in the cycle rvalid pulses (back-to-back throughput: one transaction per 2 cycles).
- Timeout:
  - If TIMEOUT ≠ 0 and the timer reaches TIMEOUT with no ack: bus_req_out clears, state goes to IDLE, and the owner gets rvalid = 1, err = 1, rdata = 0.
  - A bus_ack_in arriving in IDLE is ignored.
- Flush:
  - flush_in while in IF_BUSY, or in the same cycle as if_gnt_out, sets discard.
  - The bus transaction still completes, but if_rvalid_out/if_err_out are suppressed; discard clears on completion.
  - flush_in has no effect on DM transactions or when idle.
- Stores: dm_rdata_out = 0. rdata outputs hold their last value except that they update on completion.
- Ack and timeout in the same cycle: ack wins, with a normal response.

Decomposition:
- msrv32_pkg: state encoding localparams (IDLE = 2'd0, IF_BUSY = 2'd1, DM_BUSY = 2'd2) and grant IDs (GNT_IF = 1'b0, GNT_DM = 1'b1).
- One sub-module, msrv32_bus_timer:
  - Inputs: clk_in, rst_in, start, ack.
  - Output: expired.
  - Parameter: TIMEOUT.
  - Counter width $clog2(TIMEOUT+1).

Test Plan:
- Reset then IF req addr 0x0000_0100, ack 1 cycle later with rdata 0x0000_0013 → if_gnt at c0, bus_req c1, if_rvalid c2 with 0x13, err 0.
- IF and DM requesting together from reset → IF granted first; after completion DM (store 0x2000, wdata 0xDEADBEEF, mask 4'b0011) granted with bus_we = 1, then alternation IF/DM/IF.
- DM load with bus_ack delayed 5 cycles → bus_* stable for 5 cycles, dm_rvalid one cycle after ack, rdata matches.
- TIMEOUT = 4, no ack → bus_req drops after 4 busy cycles; dm_rvalid = 1, dm_err = 1, dm_rdata = 0; a later stray ack is ignored.
- Fetch in flight, flush_in pulsed → ack completes with no if_rvalid; the next IF request proceeds normally.
- rst_in asserted mid DM_BUSY → all outputs 0 immediately, state IDLE, no rvalid after release.
